mem_access_sched: RTL and testbench

Memory-access scheduler for the 16-bit datapath. Two requesters share the single MAR/memory/MBR path: instruction fetch (IF) and operand fetch (OP). The scheduler arbitrates between them and sequences each access: MAR load, memory read wait, MBR load, then a one-cycle destination load strobe. The strobe is `ir_ld` for an IF access or `C7` for an OP access, and `C7` loads BR from MBR.

---
 rtl/mem_access_sched.sv | 115 +++++++++++
 tb/tb_mem_access_sched.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_sched.sv
// Memory-access scheduler: arbitrates IF and OP requests onto the shared
// MAR/memory/MBR path and sequences MAR load, read wait, MBR load, dest strobe.
//
// state | meaning
// IDLE  | waiting for a request; round-robin pick on a tie
// ADDR  | mar_out stable, latency counter loaded
// READ  | mem_rd high for MEM_LAT cycles
// LOAD  | mbr_ld high, MBR captures memory data
// DEST  | C7/op_done or ir_ld/if_done strobe for the owner
module mem_access_sched #(
    parameter int MEM_LAT = 2,
    parameter int ADDR_W  = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    input  logic              op_req,
    input  logic [ADDR_W-1:0] op_addr,
    output logic              if_done,
    output logic              op_done,
    output logic [ADDR_W-1:0] mar_out,
    output logic              mem_rd,
    output logic              mbr_ld,
    output logic              C7,
    output logic              ir_ld,
    output logic              busy,
    output logic              grant
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADDR,
        S_READ,
        S_LOAD,
        S_DEST
    } state_t;

    localparam logic [3:0] LAT_M1 = 4'(MEM_LAT - 1);

    state_t            state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic [ADDR_W-1:0] mar_q, mar_d;
    logic              grant_q, grant_d;
    logic              last_op_q, last_op_d;
    logic              pick_op;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            mar_q     <= '0;
            grant_q   <= 1'b0;
            last_op_q <= 1'b1;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            mar_q     <= mar_d;
            grant_q   <= grant_d;
            last_op_q <= last_op_d;
        end
    end

    // OP wins only when IF is absent, or on a tie when IF was served last.
    assign pick_op = op_req & (~if_req | ~last_op_q);

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        mar_d     = mar_q;
        grant_d   = grant_q;
        last_op_d = last_op_q;
        case (state_q)
            S_IDLE: begin
                if (if_req || op_req) begin
                    grant_d = pick_op;
                    mar_d   = pick_op ? op_addr : if_addr;
                    state_d = S_ADDR;
                end
            end
            S_ADDR: begin
                cnt_d   = LAT_M1;
                state_d = S_READ;
            end
            S_READ: begin
                if (cnt_q == 4'd0) begin
                    state_d = S_LOAD;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            S_LOAD: begin
                state_d = S_DEST;
            end
            S_DEST: begin
                last_op_d = grant_q;
                state_d   = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign mar_out = mar_q;
    assign grant   = grant_q;
    assign busy    = (state_q != S_IDLE);
    assign mem_rd  = (state_q == S_READ);
    assign mbr_ld  = (state_q == S_LOAD);
    assign C7      = (state_q == S_DEST) &  grant_q;
    assign op_done = (state_q == S_DEST) &  grant_q;
    assign ir_ld   = (state_q == S_DEST) & ~grant_q;
    assign if_done = (state_q == S_DEST) & ~grant_q;

endmodule

// File: tb/tb_mem_access_sched.sv
// Bench for mem_access_sched: vector table on a MEM_LAT=2 instance, plus
// round-robin, mid-read reset and latency sweep (MEM_LAT=1, 15) sequences.
module tb_mem_access_sched;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic       a_if_req = 0, a_op_req = 0;
    logic [7:0] a_if_addr = 0, a_op_addr = 0;
    logic       a_if_done, a_op_done, a_mem_rd, a_mbr_ld, a_c7, a_ir_ld, a_busy, a_grant;
    logic [7:0] a_mar;

    logic       b_op_req = 0, c_op_req = 0;
    logic [7:0] b_op_addr = 8'h5A, c_op_addr = 8'hA5, bc_if_addr = 8'h00;
    logic       bc_if_req = 0;
    logic       b_if_done, b_op_done, b_mem_rd, b_mbr_ld, b_c7, b_ir_ld, b_busy, b_grant;
    logic       c_if_done, c_op_done, c_mem_rd, c_mbr_ld, c_c7, c_ir_ld, c_busy, c_grant;
    logic [7:0] b_mar, c_mar;

    mem_access_sched #(.MEM_LAT(2), .ADDR_W(8)) dut_a (
        .clk(clk), .rst_n(rst_n),
        .if_req(a_if_req), .if_addr(a_if_addr), .op_req(a_op_req), .op_addr(a_op_addr),
        .if_done(a_if_done), .op_done(a_op_done), .mar_out(a_mar), .mem_rd(a_mem_rd),
        .mbr_ld(a_mbr_ld), .C7(a_c7), .ir_ld(a_ir_ld), .busy(a_busy), .grant(a_grant)
    );

    mem_access_sched #(.MEM_LAT(1), .ADDR_W(8)) dut_b (
        .clk(clk), .rst_n(rst_n),
        .if_req(bc_if_req), .if_addr(bc_if_addr), .op_req(b_op_req), .op_addr(b_op_addr),
        .if_done(b_if_done), .op_done(b_op_done), .mar_out(b_mar), .mem_rd(b_mem_rd),
        .mbr_ld(b_mbr_ld), .C7(b_c7), .ir_ld(b_ir_ld), .busy(b_busy), .grant(b_grant)
    );

    mem_access_sched #(.MEM_LAT(15), .ADDR_W(8)) dut_c (
        .clk(clk), .rst_n(rst_n),
        .if_req(bc_if_req), .if_addr(bc_if_addr), .op_req(c_op_req), .op_addr(c_op_addr),
        .if_done(c_if_done), .op_done(c_op_done), .mar_out(c_mar), .mem_rd(c_mem_rd),
        .mbr_ld(c_mbr_ld), .C7(c_c7), .ir_ld(c_ir_ld), .busy(c_busy), .grant(c_grant)
    );

    typedef struct {
        logic        if_req;
        logic        op_req;
        logic [7:0]  if_addr;
        logic [7:0]  op_addr;
        logic [15:0] exp;
        string       name;
    } vec_t;

    vec_t vecs[$];
    int   n_pass = 0;
    int   n_total = 0;

    // {busy, mem_rd, mbr_ld, C7, ir_ld, op_done, if_done, grant, mar}
    function automatic logic [15:0] ex(input bit bs, input bit rd, input bit mb, input bit c7,
                                       input bit ir, input bit od, input bit ifd, input bit g,
                                       input logic [7:0] m);
        return {bs, rd, mb, c7, ir, od, ifd, g, m};
    endfunction

    function automatic logic [15:0] pack_a();
        return {a_busy, a_mem_rd, a_mbr_ld, a_c7, a_ir_ld, a_op_done, a_if_done, a_grant, a_mar};
    endfunction

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", nm, act, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic add(input logic ir, input logic orq, input logic [7:0] ia, input logic [7:0] oa,
                       input logic [15:0] e, input string nm);
        vec_t v;
        v.if_req = ir; v.op_req = orq; v.if_addr = ia; v.op_addr = oa; v.exp = e; v.name = nm;
        vecs.push_back(v);
    endtask

    task automatic wait_idle(input string nm);
        for (int i = 0; i < 40 && a_busy; i++) step();
        check(nm, {31'd0, a_busy}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        int g_cyc[4];
        logic g_own[4];
        logic [7:0] g_mar[4];
        int ng;
        logic prev_busy;
        int cnt_strobe;
        int b_rd, b_bs, b_dn, c_rd, c_bs, c_dn, c_mb;

        // Op access with request dropped in READ, IF access, then two ties.
        add(0, 1, 8'h00, 8'h3C, ex(1,0,0,0,0,0,0,1,8'h3C), "op_addr");
        add(0, 1, 8'h00, 8'h3C, ex(1,1,0,0,0,0,0,1,8'h3C), "op_read1");
        add(0, 0, 8'h00, 8'h00, ex(1,1,0,0,0,0,0,1,8'h3C), "op_read2_dropped");
        add(0, 0, 8'h00, 8'h00, ex(1,0,1,0,0,0,0,1,8'h3C), "op_load");
        add(0, 0, 8'h00, 8'h00, ex(1,0,0,1,0,1,0,1,8'h3C), "op_dest");
        add(0, 0, 8'h00, 8'h00, ex(0,0,0,0,0,0,0,1,8'h3C), "op_idle_hold");
        add(1, 0, 8'h10, 8'h00, ex(1,0,0,0,0,0,0,0,8'h10), "if_addr");
        add(0, 0, 8'h55, 8'h00, ex(1,1,0,0,0,0,0,0,8'h10), "if_read1");
        add(0, 0, 8'h55, 8'h00, ex(1,1,0,0,0,0,0,0,8'h10), "if_read2");
        add(0, 0, 8'h55, 8'h00, ex(1,0,1,0,0,0,0,0,8'h10), "if_load");
        add(0, 0, 8'h55, 8'h00, ex(1,0,0,0,1,0,1,0,8'h10), "if_dest");
        add(0, 0, 8'h55, 8'h00, ex(0,0,0,0,0,0,0,0,8'h10), "if_idle_hold");
        add(1, 1, 8'hA1, 8'hB2, ex(1,0,0,0,0,0,0,1,8'hB2), "tie_after_if_op");
        add(0, 0, 8'hA1, 8'hB2, ex(1,1,0,0,0,0,0,1,8'hB2), "tie1_read1");
        add(0, 0, 8'hA1, 8'hB2, ex(1,1,0,0,0,0,0,1,8'hB2), "tie1_read2");
        add(0, 0, 8'hA1, 8'hB2, ex(1,0,1,0,0,0,0,1,8'hB2), "tie1_load");
        add(0, 0, 8'hA1, 8'hB2, ex(1,0,0,1,0,1,0,1,8'hB2), "tie1_dest");
        add(0, 0, 8'hA1, 8'hB2, ex(0,0,0,0,0,0,0,1,8'hB2), "tie1_idle");
        add(1, 1, 8'hC3, 8'hD4, ex(1,0,0,0,0,0,0,0,8'hC3), "tie_after_op_if");
        add(0, 0, 8'hC3, 8'hD4, ex(1,1,0,0,0,0,0,0,8'hC3), "tie2_read1");
        add(0, 0, 8'hC3, 8'hD4, ex(1,1,0,0,0,0,0,0,8'hC3), "tie2_read2");
        add(0, 0, 8'hC3, 8'hD4, ex(1,0,1,0,0,0,0,0,8'hC3), "tie2_load");
        add(0, 0, 8'hC3, 8'hD4, ex(1,0,0,0,1,0,1,0,8'hC3), "tie2_dest");
        add(0, 0, 8'hC3, 8'hD4, ex(0,0,0,0,0,0,0,0,8'hC3), "tie2_idle");

        #3;
        check("reset_outputs", {16'd0, pack_a()}, 32'd0);
        step();
        step();
        rst_n = 1'b1;
        step();
        check("idle_after_reset", {16'd0, pack_a()}, 32'd0);

        foreach (vecs[i]) begin
            a_if_req  = vecs[i].if_req;
            a_op_req  = vecs[i].op_req;
            a_if_addr = vecs[i].if_addr;
            a_op_addr = vecs[i].op_addr;
            step();
            check(vecs[i].name, {16'd0, pack_a()}, {16'd0, vecs[i].exp});
        end

        // Round-robin with both requests held from reset release.
        rst_n = 1'b0;
        a_if_req = 1; a_op_req = 1; a_if_addr = 8'h21; a_op_addr = 8'h43;
        step();
        rst_n = 1'b1;
        ng = 0;
        prev_busy = 1'b0;
        for (int cyc = 0; cyc < 40 && ng < 4; cyc++) begin
            step();
            if (a_busy && !prev_busy) begin
                g_cyc[ng] = cyc; g_own[ng] = a_grant; g_mar[ng] = a_mar;
                ng++;
            end
            prev_busy = a_busy;
        end
        check("rr_grant_count", ng, 4);
        if (ng == 4) begin
            for (int i = 0; i < 4; i++) begin
                check($sformatf("rr_owner%0d", i), {31'd0, g_own[i]}, (i % 2 == 1) ? 32'd1 : 32'd0);
                check($sformatf("rr_mar%0d", i), {24'd0, g_mar[i]}, (i % 2 == 1) ? 32'h43 : 32'h21);
            end
            for (int i = 1; i < 4; i++)
                check($sformatf("rr_spacing%0d", i), g_cyc[i] - g_cyc[i-1], 6);
        end
        a_if_req = 0; a_op_req = 0;
        wait_idle("rr_drain");
        step();

        // IF access so last-served is IF, then OP access interrupted in READ.
        a_if_req = 1; a_if_addr = 8'h66;
        step();
        a_if_req = 0;
        for (int i = 0; i < 5; i++) step();
        a_op_req = 1; a_op_addr = 8'h77;
        step();
        a_op_req = 0;
        step();
        step();
        check("pre_reset_in_read", {31'd0, a_mem_rd}, 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_reset_outputs", {16'd0, pack_a()}, 32'd0);
        cnt_strobe = 0;
        for (int i = 0; i < 3; i++) begin
            step();
            cnt_strobe += int'(a_c7) + int'(a_op_done) + int'(a_mbr_ld) + int'(a_busy);
        end
        check("no_strobe_in_reset", cnt_strobe, 0);
        a_if_req = 1; a_op_req = 1; a_if_addr = 8'h88; a_op_addr = 8'h99;
        rst_n = 1'b1;
        step();
        check("tie_after_reset_if", {16'd0, pack_a()}, {16'd0, ex(1,0,0,0,0,0,0,0,8'h88)});
        a_if_req = 0; a_op_req = 0;
        cnt_strobe = 0;
        for (int i = 0; i < 6; i++) begin
            step();
            cnt_strobe += int'(a_c7) + int'(a_op_done);
        end
        check("no_late_op_done", cnt_strobe, 0);
        wait_idle("reset_drain");

        // Latency sweep on the MEM_LAT=1 and MEM_LAT=15 instances.
        b_op_req = 1; c_op_req = 1;
        step();
        b_op_req = 0; c_op_req = 0;
        b_rd = 0; b_bs = 0; b_dn = 0; c_rd = 0; c_bs = 0; c_dn = 0; c_mb = 0;
        for (int i = 0; i < 25; i++) begin
            b_rd += int'(b_mem_rd); b_bs += int'(b_busy); b_dn += int'(b_op_done);
            c_rd += int'(c_mem_rd); c_bs += int'(c_busy); c_dn += int'(c_op_done);
            c_mb += int'(c_mbr_ld);
            step();
        end
        check("lat1_mem_rd_cycles", b_rd, 1);
        check("lat1_busy_cycles", b_bs, 4);
        check("lat1_done_pulses", b_dn, 1);
        check("lat15_mem_rd_cycles", c_rd, 15);
        check("lat15_busy_cycles", c_bs, 18);
        check("lat15_done_pulses", c_dn, 1);
        check("lat15_mbr_ld_cycles", c_mb, 1);
        check("lat15_mar", {24'd0, c_mar}, 32'hA5);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
